// File: rtl/tdc_pkg.sv
// Shared widths, state encoding and helpers for the TDC measurement sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tdc_pkg;

   localparam int TOF_W        = 13;                  // TOF code width from the TDC
   localparam int TMO_W        = 10;                  // per-shot timeout counter width
   localparam int AVG_MAX_LOG2 = 4;                   // up to 16 shots per burst
   localparam int CLR_CYC      = 2;                   // tdc_clr high time between shots
   localparam int ACC_W        = TOF_W + AVG_MAX_LOG2; // sum of 16 codes cannot overflow
   localparam int CNT_W        = AVG_MAX_LOG2 + 1;    // shot / hit counters reach 16

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      WAIT_START,
      WAIT_STOP,
      NEXT,
      DONE
   } state_t;

   // Shot-count exponents above the supported maximum saturate.
   function automatic logic [2:0] clamp_avg(input logic [2:0] v);
      return (v > 3'(AVG_MAX_LOG2)) ? 3'(AVG_MAX_LOG2) : v;
   endfunction

endpackage

// File: rtl/tdc_shot_timer.sv
// Loadable down-counter; expired marks the last cycle of a loaded interval.
// Latency: load takes effect next cycle; expired is combinational from the count.
// Backpressure: none. Ports: clk, rst (async active-low), load/load_val, dec, expired.
import tdc_pkg::*;

module tdc_shot_timer #(
   parameter int W = TMO_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         expired
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   // A value of N loaded gives exactly N cycles; the Nth one reports expired.
   assign expired = (cnt <= W'(1));

endmodule

// File: rtl/tdc_meas_ctrl.sv
// TDC measurement sequencer: clear, arm, time each shot, average 2^n hits, hand off result.
// Latency: per shot CLR_CYC + start wait + stop wait (or timeout) + 1; res_valid the cycle after the last NEXT.
// Backpressure: res_* held stable in DONE until res_ready; meas_req ignored while busy.
// Ports: clk/rst (async active-low); meas_req/meas_abort/cfg_* control; start_det/stop_det/tof_in
// from the TDC; tdc_arm/tdc_clr to the TDC; busy; res_valid/res_ready/res_tof/res_hits/res_miss result.
import tdc_pkg::*;

module tdc_meas_ctrl (
   input  logic             clk,
   input  logic             rst,
   input  logic             meas_req,
   input  logic             meas_abort,
   input  logic [2:0]       cfg_avg_log2,
   input  logic [TMO_W-1:0] cfg_timeout,
   input  logic             start_det,
   input  logic             stop_det,
   input  logic [TOF_W-1:0] tof_in,
   output logic             tdc_arm,
   output logic             tdc_clr,
   output logic             busy,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [TOF_W-1:0] res_tof,
   output logic [CNT_W-1:0] res_hits,
   output logic             res_miss
);

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] hits;
   logic [CNT_W-1:0] shots;
   logic             miss;
   logic [2:0]       avg_q;
   logic [TMO_W-1:0] tmo_q;
   logic             aborting;   // current CLEAR ends the burst instead of arming

   logic             tmr_load;
   logic [TMO_W-1:0] tmr_val;
   logic             tmr_dec;
   logic             tmr_expired;
   logic             last_shot;
   logic             go_clear;

   assign last_shot = ((shots + CNT_W'(1)) == (CNT_W'(1) << avg_q));
   assign go_clear  = ((state == IDLE) && meas_req) ||
                      ((state != IDLE) && meas_abort) ||
                      ((state == NEXT) && !last_shot);

   // One timer serves both the clear pulse width and the stop timeout.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = TMO_W'(CLR_CYC);
      tmr_dec  = (state == CLEAR) || (state == WAIT_STOP);
      if (go_clear) begin
         tmr_load = 1'b1;
      end else if ((state == WAIT_START) && start_det) begin
         tmr_load = 1'b1;
         tmr_val  = tmo_q;
      end
   end

   tdc_shot_timer #(.W(TMO_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (tmr_dec),
      .expired  (tmr_expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         tdc_arm   <= 1'b0;
         tdc_clr   <= 1'b0;
         busy      <= 1'b0;
         res_valid <= 1'b0;
         acc       <= '0;
         hits      <= '0;
         shots     <= '0;
         miss      <= 1'b0;
         avg_q     <= '0;
         tmo_q     <= '0;
         aborting  <= 1'b0;
      end else if ((state != IDLE) && meas_abort) begin
         state     <= CLEAR;
         aborting  <= 1'b1;
         tdc_clr   <= 1'b1;
         tdc_arm   <= 1'b0;
         res_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (meas_req) begin
                  avg_q    <= clamp_avg(cfg_avg_log2);
                  tmo_q    <= (cfg_timeout == '0) ? TMO_W'(1) : cfg_timeout;
                  acc      <= '0;
                  hits     <= '0;
                  shots    <= '0;
                  miss     <= 1'b0;
                  aborting <= 1'b0;
                  busy     <= 1'b1;
                  tdc_clr  <= 1'b1;
                  state    <= CLEAR;
               end
            end
            CLEAR: begin
               if (tmr_expired) begin
                  tdc_clr <= 1'b0;
                  if (aborting) begin
                     aborting <= 1'b0;
                     busy     <= 1'b0;
                     state    <= IDLE;
                  end else begin
                     tdc_arm <= 1'b1;
                     state   <= WAIT_START;
                  end
               end
            end
            WAIT_START: begin
               // A coincident stop belongs to no started shot and is dropped.
               if (start_det) begin
                  state <= WAIT_STOP;
               end
            end
            WAIT_STOP: begin
               if (stop_det) begin
                  acc     <= acc + ACC_W'(tof_in);
                  hits    <= hits + CNT_W'(1);
                  tdc_arm <= 1'b0;
                  state   <= NEXT;
               end else if (tmr_expired) begin
                  miss    <= 1'b1;
                  tdc_arm <= 1'b0;
                  state   <= NEXT;
               end
            end
            NEXT: begin
               shots <= shots + CNT_W'(1);
               if (last_shot) begin
                  res_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  tdc_clr <= 1'b1;
                  state   <= CLEAR;
               end
            end
            DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // An average over fewer hits than shots would be biased, so report 0 instead.
   assign res_tof  = ((state == DONE) && (hits == shots)) ? TOF_W'(acc >> avg_q) : '0;
   assign res_hits = (state == DONE) ? hits : '0;
   assign res_miss = (state == DONE) ? miss : 1'b0;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
import tdc_pkg::*;

module tb_tdc_meas_ctrl;

   logic             clk = 1'b0;
   logic             rst;
   logic             meas_req, meas_abort;
   logic [2:0]       cfg_avg_log2;
   logic [TMO_W-1:0] cfg_timeout;
   logic             start_det, stop_det;
   logic [TOF_W-1:0] tof_in;
   logic             tdc_arm, tdc_clr, busy, res_valid, res_ready;
   logic [TOF_W-1:0] res_tof;
   logic [CNT_W-1:0] res_hits;
   logic             res_miss;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;
   int clr_rises    = 0;
   logic clr_prev   = 1'b0;

   // Burst description consumed by run_burst
   int cfg_a, cfg_t, abort_at, rdy_dly;
   bit req_in_wait;
   bit hit_q[16];
   bit both_q[16];
   int tof_q[16], dstart_q[16], dstop_q[16];

   tdc_meas_ctrl dut (
      .clk(clk), .rst(rst), .meas_req(meas_req), .meas_abort(meas_abort),
      .cfg_avg_log2(cfg_avg_log2), .cfg_timeout(cfg_timeout),
      .start_det(start_det), .stop_det(stop_det), .tof_in(tof_in),
      .tdc_arm(tdc_arm), .tdc_clr(tdc_clr), .busy(busy),
      .res_valid(res_valid), .res_ready(res_ready), .res_tof(res_tof),
      .res_hits(res_hits), .res_miss(res_miss)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (tdc_clr && !clr_prev) clr_rises = clr_rises + 1;
      clr_prev = tdc_clr;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_shots();
      for (int i = 0; i < 16; i++) begin
         hit_q[i] = 1'b1; both_q[i] = 1'b0; tof_q[i] = 0; dstart_q[i] = 0; dstop_q[i] = 0;
      end
      abort_at = -1; rdy_dly = 0; req_in_wait = 1'b0;
   endtask

   // Drives one burst described by the globals and checks it against the shot rules.
   task automatic run_burst();
      int a_eff, n, t_eff, exp_hits, exp_sum, exp_lat, exp_tof, c0, cnt, clr_len, rises0;
      bit exp_miss, stable, bad;
      logic [TOF_W-1:0] h_tof;
      logic [CNT_W-1:0] h_hits;
      logic             h_miss;
      a_eff = (cfg_a > AVG_MAX_LOG2) ? AVG_MAX_LOG2 : cfg_a;
      n     = 1 << a_eff;
      t_eff = (cfg_t == 0) ? 1 : cfg_t;
      exp_hits = 0; exp_sum = 0; exp_miss = 0; exp_lat = 0;
      for (int i = 0; i < n; i++) begin
         exp_lat += CLR_CYC + dstart_q[i] + 1 + 1;
         if (hit_q[i]) begin
            exp_hits++; exp_sum += tof_q[i]; exp_lat += dstop_q[i] + 1;
         end else begin
            exp_miss = 1'b1; exp_lat += t_eff;
         end
      end
      exp_tof = (exp_hits == n) ? (exp_sum >> a_eff) : 0;

      rises0 = clr_rises;
      cfg_avg_log2 = 3'(cfg_a); cfg_timeout = TMO_W'(cfg_t);
      meas_req = 1'b1; c0 = cyc;
      @(negedge clk); meas_req = 1'b0;
      check_eq("busy_on_req", busy, 1);

      for (int i = 0; i < n; i++) begin
         clr_len = 0; cnt = 0;
         while (!tdc_arm && cnt < 200) begin
            if (tdc_clr) clr_len++;
            cnt++; @(negedge clk);
         end
         check_eq("clr_len", clr_len, CLR_CYC);
         repeat (dstart_q[i]) @(negedge clk);
         start_det = 1'b1;
         if (both_q[i]) begin stop_det = 1'b1; tof_in = TOF_W'($urandom); end
         @(negedge clk); start_det = 1'b0; stop_det = 1'b0;
         if (abort_at == i) begin
            meas_abort = 1'b1; @(negedge clk); meas_abort = 1'b0;
            clr_len = 0; cnt = 0; bad = 1'b0;
            while (busy && cnt < 50) begin
               if (tdc_clr) clr_len++;
               if (tdc_arm || res_valid) bad = 1'b1;
               cnt++; @(negedge clk);
            end
            check_eq("abort_clr_len", clr_len, CLR_CYC);
            check_eq("abort_busy", busy, 0);
            repeat (4) begin
               if (res_valid || tdc_clr || tdc_arm) bad = 1'b1;
               @(negedge clk);
            end
            check_eq("abort_quiet", bad, 0);
            return;
         end
         if (hit_q[i]) begin
            repeat (dstop_q[i]) @(negedge clk);
            stop_det = 1'b1; tof_in = TOF_W'(tof_q[i]);
            @(negedge clk); stop_det = 1'b0; tof_in = TOF_W'($urandom);
         end else begin
            cnt = 0;
            while (tdc_arm && cnt < 2000) begin cnt++; @(negedge clk); end
            check_eq("stop_wait", cnt, t_eff);
         end
      end

      cnt = 0;
      while (!res_valid && cnt < 200) begin cnt++; @(negedge clk); end
      check_eq("valid_seen", res_valid, 1);
      check_eq("latency", cyc - c0 - 1, exp_lat);
      check_eq("res_tof", res_tof, exp_tof);
      check_eq("res_hits", res_hits, exp_hits);
      check_eq("res_miss", res_miss, exp_miss);
      check_eq("clr_pulses", clr_rises - rises0, n);
      h_tof = res_tof; h_hits = res_hits; h_miss = res_miss;

      stable = 1'b1;
      for (int k = 0; k < rdy_dly; k++) begin
         if (req_in_wait) meas_req = 1'b1;
         @(negedge clk);
         if (res_tof !== h_tof || res_hits !== h_hits || res_miss !== h_miss ||
             !res_valid || !busy || tdc_clr || tdc_arm) stable = 1'b0;
      end
      check_eq("hold_stable", stable, 1);
      res_ready = 1'b1;
      @(negedge clk); res_ready = 1'b0; meas_req = 1'b0;
      check_eq("ack_valid", res_valid, 0);
      check_eq("ack_busy", busy, 0);
      @(negedge clk);
      check_eq("no_restart", tdc_clr, 0);
   endtask

   initial begin
      int cnt;
      rst = 1'b0; meas_req = 1'b0; meas_abort = 1'b0; cfg_avg_log2 = '0; cfg_timeout = '0;
      start_det = 1'b0; stop_det = 1'b0; tof_in = '0; res_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_arm", tdc_arm, 0);
      check_eq("rst_clr", tdc_clr, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_valid", res_valid, 0);
      check_eq("rst_res", {res_tof, res_hits, res_miss}, 0);
      rst = 1'b1;
      @(negedge clk);

      // Single shot, stop 5 cycles after start
      clear_shots(); cfg_a = 0; cfg_t = 20; tof_q[0] = 'h123; dstart_q[0] = 2; dstop_q[0] = 4;
      run_burst();
      // Fastest shot: latency CLR_CYC + 3
      clear_shots(); cfg_a = 0; cfg_t = 5; tof_q[0] = 'h7ff;
      run_burst();
      // Averaging over four shots
      clear_shots(); cfg_a = 2; cfg_t = 30;
      tof_q[0] = 100; tof_q[1] = 101; tof_q[2] = 102; tof_q[3] = 105;
      dstop_q[1] = 3; dstart_q[2] = 1;
      run_burst();
      // Timeout with no stop
      clear_shots(); cfg_a = 0; cfg_t = 8; hit_q[0] = 1'b0;
      run_burst();
      // Stop on the last allowed cycle still counts
      clear_shots(); cfg_a = 0; cfg_t = 8; tof_q[0] = 'h0ab; dstop_q[0] = 7;
      run_burst();
      // Backpressure with requests arriving while waiting
      clear_shots(); cfg_a = 1; cfg_t = 10; tof_q[0] = 40; tof_q[1] = 43;
      rdy_dly = 20; req_in_wait = 1'b1;
      run_burst();
      // Abort in shot 2 of 4
      clear_shots(); cfg_a = 2; cfg_t = 10; abort_at = 1; tof_q[0] = 9;
      run_burst();

      // Reset in the middle of a stop wait
      cfg_avg_log2 = 3'd2; cfg_timeout = 10'd20; meas_req = 1'b1;
      @(negedge clk); meas_req = 1'b0;
      cnt = 0;
      while (!tdc_arm && cnt < 50) begin cnt++; @(negedge clk); end
      start_det = 1'b1; @(negedge clk); start_det = 1'b0;
      @(negedge clk);
      rst = 1'b0; #1;
      check_eq("async_arm", tdc_arm, 0);
      check_eq("async_busy", busy, 0);
      check_eq("async_valid", res_valid, 0);
      @(negedge clk); rst = 1'b1; @(negedge clk);
      clear_shots(); cfg_a = 0; cfg_t = 6; tof_q[0] = 'h1f00; dstart_q[0] = 1; dstop_q[0] = 2;
      run_burst();

      // Randomized bursts, including clamp and zero timeout
      for (int b = 0; b < 25; b++) begin
         int te, nn;
         clear_shots();
         cfg_a = $urandom_range(0, 7);
         cfg_t = $urandom_range(0, 12);
         te = (cfg_t == 0) ? 1 : cfg_t;
         nn = 1 << ((cfg_a > AVG_MAX_LOG2) ? AVG_MAX_LOG2 : cfg_a);
         for (int i = 0; i < 16; i++) begin
            hit_q[i]    = ($urandom_range(0, 3) != 0);
            both_q[i]   = ($urandom_range(0, 3) == 0);
            tof_q[i]    = $urandom_range(0, (1 << TOF_W) - 1);
            dstart_q[i] = $urandom_range(0, 3);
            dstop_q[i]  = $urandom_range(0, te - 1);
         end
         if ($urandom_range(0, 5) == 0) abort_at = $urandom_range(0, nn - 1);
         rdy_dly = $urandom_range(0, 4);
         req_in_wait = $urandom_range(0, 1);
         run_burst();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
